// File: rtl/food_map_pkg.sv
// Shared maze definitions: map geometry, food encodings, control states and
// the tile addressing / fill pattern helpers used by food_map.
package food_map_pkg;
    localparam int TILE_PX   = 16;
    localparam int MAP_W     = 40;
    localparam int MAP_H     = 30;
    localparam int MAP_CELLS = MAP_W * MAP_H;
    localparam int ADDR_W    = 11;

    typedef enum logic [1:0] {
        FOOD_NONE = 2'd0,
        FOOD_S    = 2'd1,
        FOOD_M    = 2'd2,
        FOOD_L    = 2'd3
    } food_t;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        EAT_RD = 2'd2,
        EAT_WR = 2'd3
    } ctl_state_t;

    typedef struct packed {
        logic [5:0] tx;
        logic [4:0] ty;
    } tile_t;

    // ty*40 + tx as two shifts and an add; never exceeds 1199 for in-map tiles.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [5:0] tx, input logic [4:0] ty);
        return {1'b0, ty, 5'b0} + {3'b0, ty, 3'b0} + {5'b0, tx};
    endfunction

    function automatic food_t fill_type(input logic [5:0] tx, input logic [4:0] ty);
        logic [1:0] diag;
        diag = tx[1:0] + ty[1:0];
        if (tx[2:0] == 3'd0 && ty[2:0] == 3'd0) return FOOD_L;
        if (diag == 2'd0) return FOOD_M;
        return FOOD_S;
    endfunction
endpackage

// File: rtl/food_ram.sv
// 1200x2 dual-port food store: a read-only render port and a read/write
// control port, both synchronous and read-first. No reset so it maps to BRAM.
module food_ram
    import food_map_pkg::*;
#(
    parameter int DEPTH = MAP_CELLS
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_data,
    input  logic [ADDR_W-1:0] ctl_addr,
    input  logic              ctl_we,
    input  logic [1:0]        ctl_wdata,
    output logic [1:0]        ctl_rdata
);
    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (ctl_we) mem[ctl_addr] <= ctl_wdata;
        ctl_rdata <= mem[ctl_addr];
    end
endmodule

// File: rtl/food_map.sv
// Food occupancy store upstream of food_layout: two-stage render lookup from the
// scan position, plus fill / eat control and the remaining-food counter.
module food_map
    import food_map_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_valid,
    output logic [3:0]  x,
    output logic [3:0]  y,
    output logic [1:0]  food_type,
    output logic        out_valid,
    input  logic        eat_req,
    input  logic [5:0]  eat_tx,
    input  logic [4:0]  eat_ty,
    output logic        eat_ack,
    output logic [1:0]  eaten_type,
    input  logic        init_start,
    output logic        init_busy,
    output logic [10:0] food_left,
    output logic        level_clear
);
    localparam int STAGES = 2;

    ctl_state_t        state, state_nx;
    logic [STAGES:1]   vld_pipe;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_data;
    logic [3:0]        x1, y1;
    logic              blank1, blank2;
    logic              pix_in_map;

    logic [5:0]        init_tx;
    logic [4:0]        init_ty;
    logic              init_last;
    tile_t             eat_tile;
    logic              eat_oob;
    logic              ctl_we;
    logic [1:0]        ctl_wdata, ctl_rdata;
    logic [ADDR_W-1:0] ctl_addr;

    assign pix_in_map = (pix_x < 10'(MAP_W * TILE_PX)) && (pix_y < 10'(MAP_H * TILE_PX));

    // Blanking is decided in stage 1 so it travels with its pixel through the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rd_addr  <= '0;
            x1       <= '0;
            y1       <= '0;
            blank1   <= 1'b1;
            x        <= '0;
            y        <= '0;
            blank2   <= 1'b1;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
            rd_addr  <= pix_in_map ? tile_addr(pix_x[9:4], pix_y[8:4]) : '0;
            x1       <= pix_x[3:0];
            y1       <= pix_y[3:0];
            blank1   <= !pix_in_map || init_busy;
            x        <= x1;
            y        <= y1;
            blank2   <= blank1;
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign food_type = blank2 ? FOOD_NONE : rd_data;

    assign init_busy = (state == INIT);
    assign init_last = (init_tx == 6'(MAP_W - 1)) && (init_ty == 5'(MAP_H - 1));

    always_comb begin
        state_nx  = state;
        ctl_we    = 1'b0;
        ctl_wdata = FOOD_NONE;
        ctl_addr  = eat_oob ? '0 : tile_addr(eat_tile.tx, eat_tile.ty);
        case (state)
            INIT: begin
                ctl_we    = 1'b1;
                ctl_wdata = fill_type(init_tx, init_ty);
                ctl_addr  = tile_addr(init_tx, init_ty);
                if (init_last) state_nx = IDLE;
            end
            IDLE: begin
                if (init_start)               state_nx = INIT;
                else if (eat_req && !eat_ack) state_nx = EAT_RD;
            end
            EAT_RD: state_nx = EAT_WR;
            EAT_WR: begin
                ctl_we   = !eat_oob;
                state_nx = IDLE;
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= INIT;
            init_tx     <= '0;
            init_ty     <= '0;
            eat_tile    <= '0;
            eat_oob     <= 1'b0;
            eat_ack     <= 1'b0;
            eaten_type  <= FOOD_NONE;
            food_left   <= '0;
            level_clear <= 1'b0;
        end else begin
            state       <= state_nx;
            eat_ack     <= 1'b0;
            level_clear <= 1'b0;
            case (state)
                INIT: begin
                    if (init_last) begin
                        init_tx   <= '0;
                        init_ty   <= '0;
                        food_left <= 11'(MAP_CELLS);
                    end else if (init_tx == 6'(MAP_W - 1)) begin
                        init_tx <= '0;
                        init_ty <= init_ty + 5'd1;
                    end else begin
                        init_tx <= init_tx + 6'd1;
                    end
                end
                IDLE: begin
                    if (!init_start && eat_req && !eat_ack) begin
                        eat_tile <= '{tx: eat_tx, ty: eat_ty};
                        eat_oob  <= (eat_tx >= 6'(MAP_W)) || (eat_ty >= 5'(MAP_H));
                    end
                end
                EAT_WR: begin
                    eat_ack    <= 1'b1;
                    eaten_type <= eat_oob ? FOOD_NONE : ctl_rdata;
                    if (!eat_oob && ctl_rdata != FOOD_NONE) begin
                        food_left   <= food_left - 11'd1;
                        level_clear <= (food_left == 11'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    food_ram u_ram (
        .clk       (clk),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ctl_addr  (ctl_addr),
        .ctl_we    (ctl_we),
        .ctl_wdata (ctl_wdata),
        .ctl_rdata (ctl_rdata)
    );
endmodule
